// File: rtl/fp_pkg.sv
// Shared binary32 constants and field layout for the FP multiplier.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/fp_mant_mul.sv
// Unsigned 24x24 significand multiplier, purely combinational.
module fp_mant_mul
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = {{MANT_W{1'b0}}, a} * {{MANT_W{1'b0}}, b};

endmodule

// File: rtl/fp_multiplier.sv
// Binary32 multiplier: RNE rounding, FTZ/DAZ, one registered output stage.
module fp_multiplier
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] final_product
);

  fp_t a;
  fp_t b;
  assign a = num1;
  assign b = num2;

  logic nan_a, nan_b, inf_a, inf_b;
  logic zero_a, zero_b, sign;

  assign nan_a  = (a.exp == EXP_MAX) && (a.frac != '0);
  assign nan_b  = (b.exp == EXP_MAX) && (b.frac != '0);
  assign inf_a  = (a.exp == EXP_MAX) && (a.frac == '0);
  assign inf_b  = (b.exp == EXP_MAX) && (b.frac == '0);
  assign zero_a = (a.exp == '0);
  assign zero_b = (b.exp == '0);
  assign sign   = a.sign ^ b.sign;

  logic [PROD_W-1:0] prod;

  fp_mant_mul u_mant_mul (
    .a ({1'b1, a.frac}),
    .b ({1'b1, b.frac}),
    .p (prod)
  );

  logic [9:0]        exp_sum;
  logic [9:0]        exp_fin;
  logic [MANT_W-1:0] mant;
  logic [MANT_W:0]   mant_r;
  logic [FRAC_W-1:0] frac_r;
  logic              guard, rnd, sticky;
  logic              round_up;

  assign exp_sum = {2'b00, a.exp} + {2'b00, b.exp}
                 - 10'(BIAS);

  always_comb begin
    mant   = prod[PROD_W-2 -: MANT_W];
    guard  = prod[22];
    rnd    = prod[21];
    sticky = |prod[20:0];
    if (prod[PROD_W-1]) begin
      mant   = prod[PROD_W-1 -: MANT_W];
      guard  = prod[23];
      rnd    = prod[22];
      sticky = |prod[21:0];
    end
  end

  // Carry out of the rounded significand means it became exactly 2.0.
  assign round_up = guard & (rnd | sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  assign frac_r   = mant_r[MANT_W] ? mant_r[MANT_W-1:1]
                                   : mant_r[FRAC_W-1:0];
  assign exp_fin  = exp_sum
                  + {9'b0, prod[PROD_W-1]}
                  + {9'b0, mant_r[MANT_W]};

  logic        ovf, unf;
  logic [31:0] result;

  assign ovf = $signed(exp_fin) >= 10'sd255;
  assign unf = $signed(exp_fin) <= 10'sd0;

  always_comb begin
    result = {sign, exp_fin[EXP_W-1:0], frac_r};
    if (nan_a || nan_b)
      result = QNAN;
    else if ((inf_a && zero_b) || (zero_a && inf_b))
      result = QNAN;
    else if (inf_a || inf_b || ovf)
      result = {sign, POS_INF[30:0]};
    else if (zero_a || zero_b || unf)
      result = {sign, 31'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      final_product <= '0;
    else
      final_product <= result;
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench: directed vectors plus random ops vs. integer model.
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] final_product;

  int checks = 0;
  int errors = 0;

  fp_multiplier dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .num1          (num1),
    .num2          (num2),
    .final_product (final_product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Exact integer product, then round to 24 significant bits by
  // comparing the discarded remainder against half an ulp.
  function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    logic        s, nx, ny, ix, iy, zx, zy;
    logic [63:0] p, q, rem, half;
    int          len, sh, e;
    s  = x[31] ^ y[31];
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    zx = (x[30:23] == 8'h00);
    zy = (y[30:23] == 8'h00);
    if (nx || ny) return 32'h7FC00000;
    if ((ix && zy) || (zx && iy)) return 32'h7FC00000;
    if (ix || iy) return {s, 8'hFF, 23'd0};
    if (zx || zy) return {s, 31'd0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    len = 0;
    for (int i = 0; i < 64; i++)
      if (p[i]) len = i + 1;
    sh   = len - 24;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    e = int'(x[30:23]) + int'(y[30:23]) - 127 + (len - 47);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic        s;
    r = $urandom;
    s = r[31];
    case ($urandom_range(0, 15))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      3: return {s, 8'h00, r[22:0]};
      4: return {s, 8'($urandom_range(1, 12)), r[22:0]};
      5: return {s, 8'($urandom_range(243, 254)), r[22:0]};
      6: return {s, 8'($urandom_range(60, 190)), r[22:2], 2'b00};
      default: return {s, 8'($urandom_range(64, 190)), r[22:0]};
    endcase
  endfunction

  task automatic apply(input string tag,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] exp);
    @(negedge clk);
    num1 = x;
    num2 = y;
    @(posedge clk);
    #1;
    check(tag, final_product, exp);
  endtask

  logic [31:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    num1  = 32'h3F800000;
    num2  = 32'h40000000;
    #1;
    check("reset_init", final_product, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold", final_product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000);
    apply("two_x_two", 32'h40000000, 32'h40000000, 32'h40800000);
    apply("ten_x_ten", 32'h41200000, 32'h41200000, 32'h42C80000);
    apply("1p5_x_1p5", 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    apply("inexact",   32'h3ECCCCCD, 32'h40A00000, 32'h40000000);
    apply("tie_even",  32'h46445C00, 32'h455A2000, 32'h4C274EE4);
    apply("zero_a",    32'h00000000, 32'h40A00000, 32'h00000000);
    apply("zero_b",    32'h40A00000, 32'h00000000, 32'h00000000);
    apply("neg_zero",  32'h80000000, 32'h40A00000, 32'h80000000);
    apply("inf_b",     32'h40A00000, 32'h7F800000, 32'h7F800000);
    apply("neg_inf",   32'hFF800000, 32'h40A00000, 32'hFF800000);
    apply("inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000);
    apply("nan_in",    32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    apply("overflow",  32'h7F000000, 32'h40000000, 32'h7F800000);
    apply("underflow", 32'h00800000, 32'h3F000000, 32'h00000000);
    apply("denorm",    32'h00400000, 32'h7F800000, 32'h7FC00000);
    apply("rnd_carry", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000);
    apply("neg_norm",  32'hC0000000, 32'h40400000, 32'hC0C00000);

    // Mid-stream reset between edges clears the output at once.
    @(negedge clk);
    num1 = 32'h40400000;
    num2 = 32'h40400000;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", final_product, 32'h0);
    @(posedge clk);
    #1;
    check("reset_clkd", final_product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_rel", final_product, 32'h0);
    @(posedge clk);
    #1;
    check("after_rst", final_product, 32'h41100000);

    for (int i = 0; i < 600; i++) begin
      ra = rand_op();
      rb = rand_op();
      apply("random", ra, rb, ref_mul(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_multiplier.md
FP_MULTIPLIER -- requirements
Module: fp_multiplier

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 num1  input  32  IEEE-754 binary32 operand A (sign[31], exp[30:23], frac[22:0]).
REQ-004 num2  input  32  IEEE-754 binary32 operand B, same format.
REQ-005 final_product  output  32  registered binary32 product num1*num2.
REQ-006 No parameters; widths fixed at binary32 (8-bit exponent, 23-bit fraction, bias 127).

Function
REQ-007 final_product SHALL be registered: inputs sampled on rising clk edge N, result visible after edge N; latency 1 cycle, throughput 1 per cycle, no handshake.
REQ-008 Result sign SHALL be num1[31] XOR num2[31] for all non-NaN results.
REQ-009 Normal operands: significands 1.frac (24 bits) SHALL be multiplied to a 48-bit product; exponent = expA + expB - 127, 10-bit signed intermediate.
REQ-010 If product bit 47 set, shift right 1 and increment exponent; otherwise bit 46 is the leading one.
REQ-011 Rounding SHALL be round-to-nearest, ties-to-even, using guard, round and sticky (OR of remaining low bits).
REQ-012 A rounding carry out of the 24-bit significand SHALL renormalize (significand 1.0, exponent +1).
REQ-013 Final biased exponent >= 255 SHALL give signed infinity (exp 0xFF, frac 0).
REQ-014 Final biased exponent <= 0 SHALL give signed zero (flush-to-zero, no subnormal outputs).
REQ-015 Operand with exp==0 (zero or subnormal) SHALL be treated as signed zero (denormals-are-zero).
REQ-016 Zero times finite SHALL give signed zero (sign per REQ-008).
REQ-017 Infinity times nonzero finite or infinity SHALL give signed infinity.
REQ-018 Infinity times zero SHALL give canonical quiet NaN 0x7FC00000.
REQ-019 Any NaN operand (exp 0xFF, frac != 0) SHALL give 0x7FC00000.
REQ-020 Special-case priority: NaN input > inf*0 > infinity > zero > normal path.
REQ-021 No exception flags are produced.

Reset
REQ-022 While rst_n low, final_product SHALL be 0x00000000 immediately, independent of clk.
REQ-023 First result after rst_n deasserts appears after the first subsequent rising clk edge; no other state exists.
REQ-024 Reset asserted mid-stream SHALL discard the pending result; no partial result is ever output.

Structure
REQ-025 Shared package fp_pkg SHALL hold: EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
REQ-026 One sub-module fp_mant_mul SHALL perform the combinational 24x24 unsigned significand multiply (48-bit result); classification, normalization, rounding and output register stay in fp_multiplier.
REQ-027 All datapath logic before the output register SHALL be combinational.

Verification
REQ-028 Basic: 0x3F800000*0x3F800000 -> 0x3F800000; 0x40000000*0x40000000 -> 0x40800000; 0x41200000*0x41200000 -> 0x42C80000; 0x3FC00000*0x3FC00000 -> 0x40100000, each one cycle after applying inputs.
REQ-029 Rounding/inexact: 0x3ECCCCCD*0x40A00000 (0.4*5) -> 0x40000000; 0x46445C00*0x455A2000 (12567*3490, exact tie) -> 0x4C274EE4 (ties-to-even).
REQ-030 Zeros: 0x00000000*0x40A00000 -> 0x00000000; 0x40A00000*0x00000000 -> 0x00000000; 0x80000000*0x40A00000 -> 0x80000000.
REQ-031 Infinity/NaN: 0x40A00000*0x7F800000 -> 0x7F800000; 0xFF800000*0x40A00000 -> 0xFF800000; 0x7F800000*0x00000000 -> 0x7FC00000; 0x7FC00001*0x3F800000 -> 0x7FC00000.
REQ-032 Range: 0x7F000000*0x40000000 -> 0x7F800000 (overflow); 0x00800000*0x3F000000 -> 0x00000000 (underflow flush).
REQ-033 Reset: drive valid inputs, assert rst_n low between clk edges -> final_product 0x00000000 immediately; release -> correct product after next rising edge.
